fifo_serial_tx: RTL and testbench
=================================

Name: fifo_serial_tx

Overview:
Reader-side companion to the team's FIFO queue. It pops words from the queue and transmits each one on a single-wire asynchronous serial line.
- Frame: start bit, WIDTH data bits LSB first, one stop bit.
- Sits between the queue's dequeue/empty/data interface and an off-block serial pin.
- Pops only when it can start a frame immediately.

Parameters:
WIDTH, 3, data word width; must equal the upstream queue width.
BIT_CYCLES, 4, clock cycles per serial bit; legal values are 1 or greater.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  synchronous, active-high reset.
tx_enable  input  1  allows a new frame to start; a frame already in progress always completes.
empty  input  1  upstream queue is empty.
fifo_data  input  WIDTH  upstream queue head word; valid in a cycle where dequeue=1 and empty=0.
dequeue  output  1  pop request to the queue (combinational).
tx  output  1  serial line, registered; idle level is 1.
busy  output  1  registered; 1 while a frame is on the line.
word_done  output  1  registered; one-cycle pulse in the last cycle of a stop bit.

Behaviour:
- Reset values (applied at the next clock edge): state=IDLE, tx=1, busy=0, word_done=0, all counters=0. dequeue is 0 while reset is high.
- Reset mid-frame: the frame aborts, tx returns to 1 at the next edge, and the word in flight is discarded with no replay.
- States and tx levels:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift register bit 0.
  - STOP: tx=1.
- Pop condition: dequeue = tx_enable & ~empty & (state==IDLE | last cycle of STOP).
  - A pop is accepted whenever dequeue=1 and empty=0.
  - In the pop cycle, fifo_data is captured into the WIDTH-bit shift register.
  - At the next edge the state becomes START, tx=0 and busy=1.
- Bit timing: a bit timer counts 0..BIT_CYCLES-1, and every bit lasts exactly BIT_CYCLES cycles. The timer's terminal count advances the state:
  - START -> DATA.
  - DATA: shift right and increment the bit index. After bit WIDTH-1, go to STOP.
  - STOP, last cycle: word_done=1.
    - If the pop condition holds, go to START: back-to-back frames with no idle gap.
    - Otherwise go to IDLE.
- Latency and length:
  - First tx=0 appears 1 cycle after the pop cycle.
  - Frame length is (WIDTH+2)*BIT_CYCLES cycles.
- Counter widths: the bit index is $clog2(WIDTH)+1 bits and the bit timer is $clog2(BIT_CYCLES)+1 bits. Neither counter wraps inside a frame.
- tx_enable deasserted mid-frame: no effect on the current frame. The next pop is blocked and the state goes to IDLE after STOP.
- empty=1 in IDLE: dequeue=0, the state stays IDLE, tx=1.
- The shift register holds the captured word. fifo_data changes after the pop cycle do not affect the frame.
- Upstream enqueue activity is irrelevant to this block; only the pop condition matters.
- busy deasserts at the edge that enters IDLE.

Decomposition:
- Package fifo_pkg:
  - typedef enum tx_state_t {IDLE, START, DATA, STOP};
  - constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- One sub-module, bit_timer (parameter BIT_CYCLES):
  - inputs: clock, reset, run.
  - output: tick, asserted in the last cycle of each bit.
  - counter clears when run=0.

Test Plan:
Single word (WIDTH=3, BIT_CYCLES=4): queue holds 3'b101, empty falls, tx_enable=1.
-> dequeue=1 for exactly 1 cycle; tx = 0,1,0,1,1, each level held 4 cycles; frame = 20 cycles; word_done pulses at cycle 20; then IDLE with tx=1, busy=0.

Back-to-back: queue holds 3'b011 then 3'b110.
-> second dequeue occurs in the last STOP cycle of frame 1; tx = 0,1,1,0,1 then 0,0,1,1,1 with no idle cycle; 2 word_done pulses 20 cycles apart.

Empty / disable: empty=1 with tx_enable=1, then empty=0 with tx_enable=0, 30 cycles each.
-> dequeue stays 0, tx=1 and busy=0 throughout; raising tx_enable gives a pop in the same cycle.

Disable mid-frame: drop tx_enable during DATA of word 3'b111 while the queue is non-empty.
-> frame completes as 0,1,1,1,1; no second pop; returns to IDLE.

Reset mid-frame: assert reset for 1 cycle during DATA bit 1.
-> tx=1, busy=0, word_done=0 at the next edge; no dequeue during reset; the next word is sent intact afterwards.

BIT_CYCLES=1 corner: word 3'b010.
-> tx = 0,0,1,0,1 on 5 consecutive cycles; frame = 5 cycles.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and line levels for the FIFO reader-side serial transmitter.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while run is high and flags the
// last cycle of each bit (tick) plus the cycle just before it (pre_tick).
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic tick,
    output logic pre_tick
);

    localparam int CNT_W = $clog2(BIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
    // With one-cycle bits there is no cycle before the terminal one.
    localparam logic HAS_PRE = (BIT_CYCLES > 1);
    localparam logic [CNT_W-1:0] PRE_CNT = CNT_W'((BIT_CYCLES > 1) ? BIT_CYCLES - 2 : 0);

    logic [CNT_W-1:0] count;

    assign tick     = run && (count == LAST_CNT);
    assign pre_tick = HAS_PRE && run && (count == PRE_CNT);

    // Count within a bit; restart at every bit boundary and hold at zero when idle.
    always_ff @(posedge clock) begin
        if (reset || !run || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from the upstream queue and sends each as an asynchronous serial
// frame: start bit, WIDTH data bits LSB first, one stop bit.
module fifo_serial_tx
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tx_enable,
    input  logic             empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             dequeue,
    output logic             tx,
    output logic             busy,
    output logic             word_done
);

    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WIDTH - 1);
    // One-cycle bits: the stop bit's only cycle is also its last.
    localparam logic ONE_CYCLE_BIT = (BIT_CYCLES == 1);

    tx_state_t        state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shifted;
    logic [IDX_W-1:0] bit_idx;
    logic             run;
    logic             tick;
    logic             pre_tick;
    logic             last_stop;
    logic             entering_stop;

    assign run           = (state != IDLE);
    assign last_stop     = (state == STOP) && tick;
    assign entering_stop = (state == DATA) && tick && (bit_idx == LAST_BIT);
    assign shreg_shifted = shreg >> 1;

    // Pop only when a frame can start right now: from IDLE, or in the final
    // stop-bit cycle so the next frame follows with no idle gap.
    assign dequeue = !reset && tx_enable && !empty && ((state == IDLE) || last_stop);

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    // Word register: load on pop, shift right after each data bit is sent.
    always_ff @(posedge clock) begin
        if (dequeue) begin
            shreg <= fifo_data;
        end else if ((state == DATA) && tick) begin
            shreg <= shreg_shifted;
        end
    end

    // Frame sequencer with registered line level, busy and word_done.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= IDLE_LEVEL;
            busy      <= 1'b0;
            word_done <= 1'b0;
            bit_idx   <= '0;
        end else begin
            // Registered one cycle early so the pulse lands on the last stop cycle.
            word_done <= (entering_stop && ONE_CYCLE_BIT) || ((state == STOP) && pre_tick);
            case (state)
                IDLE: begin
                    tx   <= IDLE_LEVEL;
                    busy <= 1'b0;
                    if (dequeue) begin
                        state <= START;
                        tx    <= START_BIT;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                            tx    <= STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx      <= shreg_shifted[0];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (dequeue) begin
                            state <= START;
                            tx    <= START_BIT;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            tx    <= IDLE_LEVEL;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= IDLE_LEVEL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: instance 0 uses 4-cycle bits, instance 1 uses
// 1-cycle bits. Directed stimulus pushes hand-written frame level patterns
// (bit i = line level of frame bit i: start, d0, d1, d2, stop) into per-instance
// queues; a monitor captures the line while busy and compares on word_done.
module tb_fifo_serial_tx;

    logic       clock;
    logic       reset;
    logic       en    [2];
    logic       empty [2];
    logic [2:0] data  [2];
    logic       deq   [2];
    logic       tx    [2];
    logic       busy  [2];
    logic       wd    [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    int pops [2];

    logic [4:0] qa [$];
    logic [4:0] qb [$];
    logic [31:0] cap_a, cap_b;
    int len_a, len_b;

    fifo_serial_tx #(.WIDTH(3), .BIT_CYCLES(4)) dut_a (
        .clock(clock), .reset(reset), .tx_enable(en[0]), .empty(empty[0]),
        .fifo_data(data[0]), .dequeue(deq[0]), .tx(tx[0]), .busy(busy[0]),
        .word_done(wd[0])
    );

    fifo_serial_tx #(.WIDTH(3), .BIT_CYCLES(1)) dut_b (
        .clock(clock), .reset(reset), .tx_enable(en[1]), .empty(empty[1]),
        .fifo_data(data[1]), .dequeue(deq[1]), .tx(tx[1]), .busy(busy[1]),
        .word_done(wd[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc_n <= cyc_n + 1;

    // Count accepted pops per instance.
    always @(negedge clock) begin
        for (int s = 0; s < 2; s++) begin
            if (deq[s] && !empty[s]) pops[s] = pops[s] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic frame_cmp(input string name, input logic [31:0] cap, input int len,
                             input logic [4:0] pat, input int bc);
        logic [31:0] e;
        e = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < bc; j++)
                e[i*bc+j] = pat[i];
        check({name, "_len"}, len, 5 * bc);
        check({name, "_bits"}, cap, e);
    endtask

    // Scoreboard monitor for instance 0.
    always @(negedge clock) begin
        if (reset || !busy[0]) begin
            len_a = 0;
            cap_a = '0;
        end else begin
            if (len_a < 32) cap_a[len_a] = tx[0];
            len_a++;
            if (wd[0]) begin
                if (qa.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_a: got unexpected word_done expected none (cycle %0d)", cyc_n);
                end else begin
                    frame_cmp("frame_a", cap_a, len_a, qa.pop_front(), 4);
                end
                len_a = 0;
                cap_a = '0;
            end
        end
    end

    // Scoreboard monitor for instance 1.
    always @(negedge clock) begin
        if (reset || !busy[1]) begin
            len_b = 0;
            cap_b = '0;
        end else begin
            if (len_b < 32) cap_b[len_b] = tx[1];
            len_b++;
            if (wd[1]) begin
                if (qb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_b: got unexpected word_done expected none (cycle %0d)", cyc_n);
                end else begin
                    frame_cmp("frame_b", cap_b, len_b, qb.pop_front(), 1);
                end
                len_b = 0;
                cap_b = '0;
            end
        end
    end

    task automatic push_exp(input int sel, input logic [4:0] pat);
        if (sel == 0) qa.push_back(pat);
        else qb.push_back(pat);
    endtask

    task automatic wait_wd(input int sel, input int budget, input string name, output int c);
        bit ok;
        ok = 1'b0;
        c = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            if (wd[sel]) begin
                ok = 1'b1;
                c = cyc_n;
            end
        end
        check({name, "_wd_seen"}, ok, 1);
    endtask

    // One word from idle; starts and ends just after a rising edge.
    task automatic single_word(input int sel, input logic [2:0] w, input logic [4:0] pat,
                               input int bc, input string name);
        int p0, c0, c1;
        p0 = pops[sel];
        push_exp(sel, pat);
        data[sel] = w;
        empty[sel] = 1'b0;
        @(negedge clock);
        check({name, "_deq"}, deq[sel], 1);
        c0 = cyc_n;
        @(posedge clock); #1;
        empty[sel] = 1'b1;
        data[sel] = ~w;
        @(negedge clock);
        check({name, "_first_tx_busy"}, {tx[sel], busy[sel]}, 2'b01);
        wait_wd(sel, 60, name, c1);
        check({name, "_frame_cycles"}, c1 - c0, 5 * bc);
        @(negedge clock);
        check({name, "_idle_after"}, {tx[sel], busy[sel], deq[sel]}, 3'b100);
        check({name, "_pop_count"}, pops[sel] - p0, 1);
        @(posedge clock); #1;
    endtask

    // Two queued words sent back to back.
    task automatic b2b(input int sel, input logic [2:0] w1, input logic [4:0] p1,
                       input logic [2:0] w2, input logic [4:0] p2, input int bc,
                       input string name);
        int p0, c0, c1, c2;
        bit found;
        logic wd_at_pop, tx_at_pop;
        p0 = pops[sel];
        push_exp(sel, p1);
        push_exp(sel, p2);
        data[sel] = w1;
        empty[sel] = 1'b0;
        @(negedge clock);
        check({name, "_deq1"}, deq[sel], 1);
        c0 = cyc_n;
        @(posedge clock); #1;
        data[sel] = w2;
        found = 1'b0;
        c1 = 0;
        wd_at_pop = 1'b0;
        tx_at_pop = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clock);
            if (deq[sel]) begin
                found = 1'b1;
                c1 = cyc_n;
                wd_at_pop = wd[sel];
                tx_at_pop = tx[sel];
            end
        end
        check({name, "_deq2_seen"}, found, 1);
        check({name, "_deq2_in_last_stop"}, {wd_at_pop, tx_at_pop}, 2'b11);
        check({name, "_deq2_cycle"}, c1 - c0, 5 * bc);
        @(posedge clock); #1;
        empty[sel] = 1'b1;
        wait_wd(sel, 60, name, c2);
        check({name, "_wd_spacing"}, c2 - c1, 5 * bc);
        @(negedge clock);
        check({name, "_idle_after"}, {tx[sel], busy[sel], deq[sel]}, 3'b100);
        check({name, "_pop_count"}, pops[sel] - p0, 2);
        @(posedge clock); #1;
    endtask

    initial begin
        int p0, c0, c1, bad;
        pops[0] = 0;
        pops[1] = 0;
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            en[s] = 1'b1;
            empty[s] = 1'b0;
            data[s] = 3'b000;
        end

        // Reset: no pop while reset is high, idle outputs after the edge.
        @(negedge clock);
        check("rst_deq_a", deq[0], 0);
        check("rst_deq_b", deq[1], 0);
        @(posedge clock); #1;
        empty[0] = 1'b1;
        empty[1] = 1'b1;
        @(negedge clock);
        check("rst_out_a", {tx[0], busy[0], wd[0]}, 3'b100);
        check("rst_out_b", {tx[1], busy[1], wd[1]}, 3'b100);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Single word 3'b101 -> 0,1,0,1,1.
        single_word(0, 3'b101, 5'b11010, 4, "single_a");

        // Back to back 3'b011 -> 0,1,1,0,1 then 3'b110 -> 0,0,1,1,1.
        b2b(0, 3'b011, 5'b10110, 3'b110, 5'b11100, 4, "b2b_a");

        // Empty with enable, then data with enable low.
        bad = 0;
        empty[0] = 1'b1;
        en[0] = 1'b1;
        repeat (30) begin
            @(negedge clock);
            if (deq[0] || !tx[0] || busy[0]) bad++;
        end
        check("hold_empty", bad, 0);
        @(posedge clock); #1;
        empty[0] = 1'b0;
        en[0] = 1'b0;
        data[0] = 3'b101;
        bad = 0;
        repeat (30) begin
            @(negedge clock);
            if (deq[0] || !tx[0] || busy[0]) bad++;
        end
        check("hold_disabled", bad, 0);
        @(posedge clock); #1;
        p0 = pops[0];
        push_exp(0, 5'b11010);
        en[0] = 1'b1;
        @(negedge clock);
        check("enable_pop_same_cycle", deq[0], 1);
        c0 = cyc_n;
        @(posedge clock); #1;
        empty[0] = 1'b1;
        wait_wd(0, 60, "enable", c1);
        check("enable_frame_cycles", c1 - c0, 20);
        check("enable_pop_count", pops[0] - p0, 1);
        @(posedge clock); #1;

        // Disable mid-frame: 3'b111 completes, no further pop.
        p0 = pops[0];
        push_exp(0, 5'b11110);
        data[0] = 3'b111;
        empty[0] = 1'b0;
        @(negedge clock);
        c0 = cyc_n;
        @(posedge clock); #1;
        data[0] = 3'b010;
        repeat (6) @(posedge clock);
        #1;
        en[0] = 1'b0;
        wait_wd(0, 60, "disable", c1);
        check("disable_frame_cycles", c1 - c0, 20);
        bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (deq[0] || !tx[0] || busy[0]) bad++;
        end
        check("disable_idle_after", bad, 0);
        check("disable_pop_count", pops[0] - p0, 1);
        @(posedge clock); #1;
        empty[0] = 1'b1;
        en[0] = 1'b1;
        @(posedge clock); #1;

        // Reset during data bit 1 of 3'b001; that word is dropped.
        p0 = pops[0];
        data[0] = 3'b001;
        empty[0] = 1'b0;
        @(negedge clock);
        @(posedge clock); #1;
        empty[0] = 1'b1;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        empty[0] = 1'b0;
        data[0] = 3'b110;
        @(negedge clock);
        check("midrst_deq_blocked", deq[0], 0);
        check("midrst_busy_before", busy[0], 1);
        @(posedge clock); #1;
        reset = 1'b0;
        push_exp(0, 5'b11100);
        @(negedge clock);
        check("midrst_out_after", {tx[0], busy[0], wd[0]}, 3'b100);
        check("midrst_repop", deq[0], 1);
        c0 = cyc_n;
        @(posedge clock); #1;
        empty[0] = 1'b1;
        wait_wd(0, 60, "midrst", c1);
        check("midrst_frame_cycles", c1 - c0, 20);
        check("midrst_pop_count", pops[0] - p0, 2);
        @(posedge clock); #1;

        // One-cycle bits: 3'b010 -> 0,0,1,0,1, then back to back.
        single_word(1, 3'b010, 5'b10100, 1, "single_b");
        b2b(1, 3'b011, 5'b10110, 3'b110, 5'b11100, 1, "b2b_b");

        repeat (3) @(posedge clock);
        check("queue_a_drained", qa.size(), 0);
        check("queue_b_drained", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
